// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b (mod 2^WIDTH) one bit per clock, LSB first,
// with a final borrow flag, behind a start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             diff_bit,
    output logic             bit_valid
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             diff_bit_q, diff_bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Full-subtractor cell on the current LSBs
    logic cell_d;
    logic cell_br;

    always_comb begin
        cell_d  = sa_q[0] ^ sb_q[0] ^ br_q;
        cell_br = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sd_d        = sd_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        diff_bit_d  = diff_bit_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    sd_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d        = {1'b0, sa_q[WIDTH-1:1]};
                sb_d        = {1'b0, sb_q[WIDTH-1:1]};
                sd_d        = {cell_d, sd_q[WIDTH-1:1]};
                br_d        = cell_br;
                diff_bit_d  = cell_d;
                bit_valid_d = 1'b1;
                cnt_d       = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // Last bit: publish the result on the same edge it completes
                    cnt_d    = '0;
                    diff_d   = {cell_d, sd_q[WIDTH-1:1]};
                    borrow_d = cell_br;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sa_q        <= '0;
            sb_q        <= '0;
            sd_q        <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            diff_bit_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sd_q        <= sd_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            diff_bit_q  <= diff_bit_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign diff_bit   = diff_bit_q;
    assign bit_valid  = bit_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timetable model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out, diff_bit, bit_valid;
    logic [W-1:0] diff;

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .diff_bit   (diff_bit),
        .bit_valid  (bit_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: k_m counts cycles since the accepted start (-1 = idle). Outputs follow
    // the latency table: busy in cycles 0..W-1, bit i valid in cycle i+1, done in cycle W.
    int           k_m;
    logic [W-1:0] res_m, diff_m;
    logic         brw_m, bor_m;

    always @(posedge clk) begin
        if (rst) begin
            k_m    <= -1;
            diff_m <= '0;
            bor_m  <= 1'b0;
        end else if (k_m == -1) begin
            if (start) begin
                k_m   <= 0;
                res_m <= a - b;
                brw_m <= (a < b);
            end
        end else if (k_m < W) begin
            k_m <= k_m + 1;
            if (k_m == W - 1) begin
                diff_m <= res_m;
                bor_m  <= brw_m;
            end
        end else begin
            k_m <= -1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", busy, (k_m >= 0 && k_m < W));
            check("done", done, (k_m == W));
            check("bit_valid", bit_valid, (k_m >= 1 && k_m <= W));
            check("diff_hold", diff, diff_m);
            check("borrow_hold", borrow_out, bor_m);
            if (k_m >= 1 && k_m <= W) check("diff_bit", diff_bit, res_m[k_m-1]);
        end
    end

    // Issue one operation from a negedge; optionally pulse start (a=b=1) at cycle poke.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_d, input logic exp_b, input int poke);
        logic [W-1:0] bits;
        int n;
        int lat;
        bit seen;
        a = av;
        b = bv;
        start = 1'b1;
        bits = '0;
        n = 0;
        lat = -1;
        seen = 1'b0;
        while (!seen && n < 4 * W) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (bit_valid && n >= 2 && n - 2 < W) bits[n-2] = diff_bit;
            if (done) begin
                seen = 1'b1;
                lat = n;
            end
            if (n - 1 == poke) begin
                start = 1'b1;
                a = 1;
                b = 1;
            end
        end
        check("latency", lat, W + 1);
        check("diff", diff, exp_d);
        check("borrow", borrow_out, exp_b);
        check("serial_bits", bits, exp_d);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_no_done(input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("no_spurious_done", cnt, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rd;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_diff_bit", diff_bit, 0);
        rst = 1'b0;
        check_en = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd37, 8'd63, 1'b0, -1);
        run_op(8'd5, 8'd10, 8'd251, 1'b1, -1);
        run_op(8'd0, 8'd1, 8'd255, 1'b1, -1);
        run_op(8'd255, 8'd255, 8'd0, 1'b0, -1);
        run_op(8'd0, 8'd0, 8'd0, 1'b0, -1);
        run_op(8'd255, 8'd0, 8'd255, 1'b0, -1);

        // Start during RUN and during DONE must be dropped
        run_op(8'd200, 8'd100, 8'd100, 1'b0, 3);
        expect_no_done(2 * W);
        run_op(8'd50, 8'd60, 8'd246, 1'b1, W);
        expect_no_done(2 * W);

        // Reset on the 4th RUN cycle aborts without a done
        a = 8'd200;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        check("abort_bit_valid", bit_valid, 0);
        check("abort_diff_bit", diff_bit, 0);
        expect_no_done(2 * W);
        run_op(8'd9, 8'd4, 8'd5, 1'b0, -1);

        // Back-to-back random vectors
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rd = ra - rb;
            run_op(ra, rb, rd, (ra < rb), -1);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
